// File: rtl/conv_ctrl_pkg.sv
// Shared defaults, index width and FSM state type for the coefficient loader.
package conv_ctrl_pkg;

   localparam int unsigned COEF_W_DEF = 16;
   localparam int unsigned N_COEF_DEF = 25;
   localparam int unsigned IDX_W      = 6;

   typedef enum logic [1:0] {
      StIdle,
      StCommit,
      StStream,
      StDone
   } state_e;

endpackage

// File: rtl/strobe_sync.sv
// Two-flop synchroniser for an asynchronous request level, plus rising-edge detect.
module strobe_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic strobe_i,
   output logic level_o,
   output logic rise_o
);

   // [0],[1] are the synchroniser stages; [2] remembers the previous synchronised level
   logic [2:0] sync_q, sync_d;

   // shift the raw level one stage per clock
   always_comb begin
      sync_d = {sync_q[1:0], strobe_i};
   end

   // synchroniser and history registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign level_o = sync_q[1];
   assign rise_o  = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/coef_load_ctrl.sv
// Coefficient loader: AXI-side writes fill a shadow bank; on a vsync edge the
// shadow is committed to the active bank and streamed to the convolution engine.
// Optional feature macro: COEF_READBACK_EN (shadow readback over the read strobe).
module coef_load_ctrl
   import conv_ctrl_pkg::*;
#(
   parameter int unsigned COEF_W             = COEF_W_DEF,
   parameter int unsigned N_COEF             = N_COEF_DEF,
   parameter bit          RELOAD_EVERY_FRAME = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_strobe_i,
   input  logic [7:0]        addr_i,
   input  logic [31:0]       wr_data_i,
   output logic              wr_ack_o,
   input  logic              rd_strobe_i,
   output logic              rd_ack_o,
   output logic [31:0]       rd_data_o,
   input  logic              vs_i,
   output logic [COEF_W-1:0] coeff_o,
   output logic              coeff_valid_o,
   output logic [IDX_W-1:0]  coeff_idx_o,
   output logic              load_done_o,
   output logic              pending_o
);

   logic              wr_level, wr_rise, wr_hit;
   logic [IDX_W-1:0]  wr_idx;
   state_e            state_q, state_d;
   logic [IDX_W-1:0]  k_q, k_d;
   logic              vs_q;
   logic              dirty_q, dirty_d;
   logic [COEF_W-1:0] shadow_q [N_COEF];
   logic [COEF_W-1:0] shadow_d [N_COEF];
   logic [COEF_W-1:0] active_q [N_COEF];
   logic [COEF_W-1:0] active_d [N_COEF];
   logic [COEF_W-1:0] act_sel;
   logic [COEF_W-1:0] coeff_q, coeff_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              valid_q, valid_d;
   logic              done_q, done_d;
   logic              wr_ack_q, wr_ack_d;
   logic              unused_bits;

   strobe_sync u_wr_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .strobe_i (wr_strobe_i),
      .level_o  (wr_level),
      .rise_o   (wr_rise)
   );

   assign wr_idx = addr_i[7:2];
   // out-of-range writes are still acknowledged, just not stored
   assign wr_hit = wr_rise && (32'(wr_idx) < N_COEF);

   // write handshake: ack rises after the edge, holds while the request stays high
   always_comb begin
      wr_ack_d = wr_rise | (wr_ack_q & wr_level);
   end

   // bank update: commit copies the pre-write shadow; a same-cycle write keeps dirty set
   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      dirty_d  = dirty_q;
      if (state_q == StCommit) begin
         active_d = shadow_q;
         dirty_d  = 1'b0;
      end
      if (wr_hit) begin
         for (int i = 0; i < int'(N_COEF); i++) begin
            if (wr_idx == IDX_W'(i)) begin
               shadow_d[i] = wr_data_i[COEF_W-1:0];
            end
         end
         dirty_d = 1'b1;
      end
   end

   // select the active coefficient addressed by the stream counter
   always_comb begin
      act_sel = '0;
      for (int i = 0; i < int'(N_COEF); i++) begin
         if (k_q == IDX_W'(i)) begin
            act_sel = active_q[i];
         end
      end
   end

   // FSM next state and registered-output next values
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      coeff_d = coeff_q;
      idx_d   = idx_q;
      valid_d = 1'b0;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (vs_i && !vs_q && (RELOAD_EVERY_FRAME || dirty_q)) begin
               state_d = StCommit;
            end
         end
         StCommit: begin
            k_d     = '0;
            state_d = StStream;
         end
         StStream: begin
            valid_d = 1'b1;
            idx_d   = k_q;
            coeff_d = act_sel;
            if (32'(k_q) == N_COEF - 1) begin
               state_d = StDone;
            end else begin
               k_d = k_q + IDX_W'(1);
            end
         end
         StDone: begin
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // all state, banks and outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         k_q      <= '0;
         vs_q     <= 1'b0;
         dirty_q  <= 1'b0;
         shadow_q <= '{default: '0};
         active_q <= '{default: '0};
         coeff_q  <= '0;
         idx_q    <= '0;
         valid_q  <= 1'b0;
         done_q   <= 1'b0;
         wr_ack_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         vs_q     <= vs_i;
         dirty_q  <= dirty_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
         coeff_q  <= coeff_d;
         idx_q    <= idx_d;
         valid_q  <= valid_d;
         done_q   <= done_d;
         wr_ack_q <= wr_ack_d;
      end
   end

   assign coeff_o       = coeff_q;
   assign coeff_idx_o   = idx_q;
   assign coeff_valid_o = valid_q;
   assign load_done_o   = done_q;
   assign pending_o     = dirty_q;
   assign wr_ack_o      = wr_ack_q;

`ifdef COEF_READBACK_EN
   logic              rd_level, rd_rise;
   logic [IDX_W-1:0]  rd_idx;
   logic [COEF_W-1:0] shd_sel;
   logic [31:0]       rd_data_q, rd_data_d;
   logic              rd_ack_q, rd_ack_d;

   strobe_sync u_rd_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .strobe_i (rd_strobe_i),
      .level_o  (rd_level),
      .rise_o   (rd_rise)
   );

   assign rd_idx = addr_i[7:2];

   // readback mux over the shadow bank
   always_comb begin
      shd_sel = '0;
      for (int i = 0; i < int'(N_COEF); i++) begin
         if (rd_idx == IDX_W'(i)) begin
            shd_sel = shadow_q[i];
         end
      end
   end

   // capture read data on the edge; same 4-phase ack as writes
   always_comb begin
      rd_data_d = rd_data_q;
      rd_ack_d  = rd_rise | (rd_ack_q & rd_level);
      if (rd_rise) begin
         rd_data_d = (32'(rd_idx) < N_COEF) ? 32'(shd_sel) : 32'hFFFF_FFFF;
      end
   end

   // read handshake registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
         rd_ack_q  <= 1'b0;
      end else begin
         rd_data_q <= rd_data_d;
         rd_ack_q  <= rd_ack_d;
      end
   end

   assign rd_ack_o  = rd_ack_q;
   assign rd_data_o = rd_data_q;
`else
   assign rd_ack_o  = 1'b0;
   assign rd_data_o = '0;
`endif

   // upper write-data bits (and the read strobe without readback) are intentionally ignored
   assign unused_bits = ^{wr_data_i, rd_strobe_i};

endmodule
